// File: rtl/spi_evt_tx_pkg.sv
// rtl/spi_evt_tx_pkg.sv - shared types and constants for the FPGA->AVR event channel
// Purpose: frame FSM state type, STATUS byte layout and the filler byte sent
//          when the event FIFO runs dry during a frame.
// Ports:   none (package).
package spi_evt_tx_pkg;

  localparam int         STATUS_OVF_BIT = 7;
  localparam logic [7:0] EMPTY_BYTE     = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STATUS,
    ST_DATA
  } frame_state_e;

  // STATUS = {ovf, 2'b00, occupancy[4:0]}
  function automatic logic [7:0] status_byte(input logic ovf_f, input logic [4:0] cnt);
    logic [7:0] s;
    s = {3'b000, cnt};
    s[STATUS_OVF_BIT] = ovf_f;
    return s;
  endfunction

endpackage

// File: rtl/spi_evt_tx_if.sv
// rtl/spi_evt_tx_if.sv - event push bus and AVR SPI pins for spi_evt_tx
// Purpose: bundles the producer push strobe/data/full and the SPI slave pins.
// Ports (signals):
//   evt_stb, evt_data, evt_full      producer push side
//   spics_n, spick, spido            AVR master -> FPGA (asynchronous)
//   spidi, spiint_n, tx_active       FPGA -> AVR data, service request, pin mux select
interface spi_evt_tx_if;
  logic       evt_stb;
  logic [7:0] evt_data;
  logic       evt_full;
  logic       spics_n;
  logic       spick;
  logic       spido;
  logic       spidi;
  logic       spiint_n;
  logic       tx_active;

  modport master (
    output evt_stb, evt_data, spics_n, spick, spido,
    input  evt_full, spidi, spiint_n, tx_active
  );

  modport slave (
    input  evt_stb, evt_data, spics_n, spick, spido,
    output evt_full, spidi, spiint_n, tx_active
  );
endinterface

// File: rtl/spi_evt_tx_fifo.sv
// rtl/spi_evt_tx_fifo.sv - synchronous byte FIFO holding outbound events
// Purpose: 2**DEPTH_LOG2 entry FIFO. A push while full is accepted only when a
//          pop commits in the same cycle. head_next exposes the entry behind the
//          head so the reader can load the following byte on the pop cycle.
// Ports:
//   fclk, rst        clock, synchronous active-high reset
//   push, din        write strobe and byte
//   pop              read strobe (ignored when empty)
//   head, head_next  entries at the read pointer and the one after it
//   count            occupancy, DEPTH_LOG2+1 bits
//   full, empty      occupancy flags
module evt_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  fclk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            din,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic [7:0]            head_next,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_nxt;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count == DEPTH_CNT);
  assign empty     = ~|count;
  assign do_pop    = pop & ~empty;
  // A slot freed by a same-cycle pop makes room for the push even when full.
  assign do_push   = push & (~full | do_pop);
  assign rd_nxt    = rd_ptr + 1'b1;
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_nxt];

  always_ff @(posedge fclk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_nxt;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/spi_evt_tx.sv
// rtl/spi_evt_tx.sv - FPGA->AVR event channel drained by the AVR as SPI master
// Purpose: producers push bytes into evt_fifo; the AVR reads a frame of
//          STATUS followed by FIFO bytes (8'hFF once empty). A byte is only
//          committed (popped) when its 8th rising spick edge arrives.
// Ports:
//   fclk         system clock
//   rst          synchronous active-high reset
//   bus (slave)  evt_stb/evt_data/evt_full push side; spics_n/spick/spido in,
//                spidi/spiint_n/tx_active out
module spi_evt_tx
  import spi_evt_tx_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        fclk,
  input  logic        rst,
  spi_evt_tx_if.slave bus
);
  logic [SYNC_STAGES-1:0] sck_pipe;
  logic [SYNC_STAGES-1:0] cs_pipe;
  logic [SYNC_STAGES-1:0] do_pipe;
  logic                   sck_prev;
  logic                   cs_prev;
  logic                   spido_q_unused;
  logic                   sck_sync;
  logic                   cs_sync;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_fall;

  frame_state_e           state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic                   loaded_data;
  logic                   ovf;
  logic                   spidi_q;
  logic                   spiint_q;
  logic                   tx_active_q;

  logic                   byte_done;
  logic                   pop;
  logic                   ovf_set;
  logic [7:0]             next_byte;
  logic                   next_has_data;

  logic [7:0]             head;
  logic [7:0]             head_next;
  logic [DEPTH_LOG2:0]    count;
  logic                   full;
  logic                   empty;

  evt_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .fclk      (fclk),
    .rst       (rst),
    .push      (bus.evt_stb),
    .din       (bus.evt_data),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign sck_sync = sck_pipe[SYNC_STAGES-1];
  assign cs_sync  = cs_pipe[SYNC_STAGES-1];
  assign sck_rise = sck_sync & ~sck_prev;
  assign sck_fall = ~sck_sync & sck_prev;
  assign cs_fall  = ~cs_sync & cs_prev;

  assign byte_done = (state != ST_IDLE) & ~cs_sync & sck_rise & (bit_cnt == 3'd7);
  // Only a data byte that actually carried a FIFO entry consumes it.
  assign pop       = byte_done & (state == ST_DATA) & loaded_data;
  assign ovf_set   = bus.evt_stb & full & ~pop;

  // The byte that follows is loaded on the completion cycle; when that cycle
  // also pops, the current head is already gone, so take the entry behind it.
  always_comb begin
    next_byte     = EMPTY_BYTE;
    next_has_data = 1'b0;
    if (pop) begin
      next_has_data = |count[DEPTH_LOG2:1];
      if (next_has_data) begin
        next_byte = head_next;
      end
    end else begin
      next_has_data = ~empty;
      if (~empty) begin
        next_byte = head;
      end
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      sck_pipe       <= '0;
      cs_pipe        <= '1;
      do_pipe        <= '0;
      sck_prev       <= 1'b0;
      cs_prev        <= 1'b1;
      spido_q_unused <= 1'b0;
      state          <= ST_IDLE;
      bit_cnt        <= 3'd0;
      shift_reg      <= EMPTY_BYTE;
      loaded_data    <= 1'b0;
      ovf            <= 1'b0;
      spidi_q        <= 1'b1;
      spiint_q       <= 1'b1;
      tx_active_q    <= 1'b0;
    end else begin
      sck_pipe       <= {sck_pipe[SYNC_STAGES-2:0], bus.spick};
      cs_pipe        <= {cs_pipe[SYNC_STAGES-2:0], bus.spics_n};
      do_pipe        <= {do_pipe[SYNC_STAGES-2:0], bus.spido};
      sck_prev       <= sck_sync;
      cs_prev        <= cs_sync;
      spido_q_unused <= do_pipe[SYNC_STAGES-1];
      spiint_q       <= empty;

      // An overflowing push beats the STATUS-read clear.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (byte_done && state == ST_STATUS) begin
        ovf <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          spidi_q <= 1'b1;
          bit_cnt <= 3'd0;
          if (cs_fall) begin
            state       <= ST_STATUS;
            tx_active_q <= 1'b1;
            shift_reg   <= status_byte(ovf, 5'(count));
            spidi_q     <= ovf;
            loaded_data <= 1'b0;
          end
        end
        ST_STATUS, ST_DATA: begin
          if (cs_sync) begin
            // End of frame or mid-byte abort: nothing uncommitted is popped.
            state       <= ST_IDLE;
            tx_active_q <= 1'b0;
            bit_cnt     <= 3'd0;
            spidi_q     <= 1'b1;
            loaded_data <= 1'b0;
          end else if (sck_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              shift_reg   <= next_byte;
              loaded_data <= next_has_data;
              state       <= ST_DATA;
            end
          end else if (sck_fall) begin
            // First fall of a byte presents the freshly loaded MSB unshifted.
            if (bit_cnt == 3'd0) begin
              spidi_q <= shift_reg[7];
            end else begin
              shift_reg <= {shift_reg[6:0], 1'b0};
              spidi_q   <= shift_reg[6];
            end
          end
        end
        default: begin
          state       <= ST_IDLE;
          tx_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.evt_full  = full;
  assign bus.spidi     = spidi_q;
  assign bus.spiint_n  = spiint_q;
  assign bus.tx_active = tx_active_q;
endmodule

// File: tb/tb_spi_evt_tx.sv
// tb/tb_spi_evt_tx.sv - self-checking bench for spi_evt_tx
module tb_spi_evt_tx;
  logic fclk = 1'b0;
  logic rst;
  always #5 fclk = ~fclk;

  spi_evt_tx_if bus();

  spi_evt_tx #(.DEPTH_LOG2(4), .SYNC_STAGES(2)) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [7:0]  m_q[$];
  logic        m_ovf;
  logic        chk_en;
  int          prev_cnt;
  logic [3:0]  cs_hist;
  logic [7:0]  last_frame [0:31];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the queue model; outputs only change on posedge.
  initial begin
    cs_hist  = 4'hF;
    prev_cnt = 0;
    forever begin
      @(negedge fclk);
      #1;
      if (rst) begin
        cs_hist  = 4'hF;
        prev_cnt = 0;
      end else begin
        if (chk_en) begin
          chk("evt_full", {7'd0, bus.evt_full}, {7'd0, m_q.size() == 16});
          chk("spiint_n", {7'd0, bus.spiint_n}, {7'd0, prev_cnt == 0});
          chk("tx_active", {7'd0, bus.tx_active}, {7'd0, ~cs_hist[2]});
          if (cs_hist[2]) chk("idle spidi", {7'd0, bus.spidi}, 8'd1);
        end
        cs_hist  = {cs_hist[2:0], bus.spics_n};
        prev_cnt = m_q.size();
      end
    end
  end

  task automatic push(input logic [7:0] v);
    bus.evt_stb  = 1'b1;
    bus.evt_data = v;
    @(negedge fclk);
    bus.evt_stb = 1'b0;
    if (m_q.size() < 16) m_q.push_back(v);
    else m_ovf = 1'b1;
  endtask

  // Reads nbytes whole bytes, then optionally abort_bits of one more byte.
  // push_byte >= 0 strobes push_val in the completion cycle of that byte.
  task automatic frame(input int nbytes, input int abort_bits, input int push_byte,
                       input logic [7:0] push_val);
    logic [7:0] exp_b, exp_next, got;
    logic       has;
    int         nb;
    exp_b    = {m_ovf, 2'b00, 5'(m_q.size())};
    exp_next = 8'hFF;
    has      = 1'b0;
    bus.spics_n = 1'b0;
    repeat (6) @(negedge fclk);
    for (int b = 0; b < nbytes + ((abort_bits > 0) ? 1 : 0); b++) begin
      nb  = (b < nbytes) ? 8 : abort_bits;
      got = 8'h00;
      for (int i = 0; i < nb; i++) begin
        got       = {got[6:0], bus.spidi};
        bus.spick = 1'b1;
        bus.spido = 1'($urandom_range(0, 1));
        for (int h = 0; h < 6; h++) begin
          @(negedge fclk);
          if (i == 7 && h == 1 && b == push_byte) begin
            bus.evt_stb  = 1'b1;
            bus.evt_data = push_val;
          end
          if (i == 7 && h == 2) begin
            bus.evt_stb = 1'b0;
            if (b == 0) m_ovf = 1'b0;
            else if (has) void'(m_q.pop_front());
            has      = (m_q.size() != 0);
            exp_next = has ? m_q[0] : 8'hFF;
            if (b == push_byte) begin
              if (m_q.size() < 16) m_q.push_back(push_val);
              else m_ovf = 1'b1;
            end
          end
        end
        bus.spick = 1'b0;
        repeat (6) @(negedge fclk);
      end
      if (b < nbytes) begin
        last_frame[b] = got;
        chk($sformatf("frame byte %0d", b), got, exp_b);
        exp_b = exp_next;
      end else begin
        chk("aborted partial bits", got, exp_b >> (8 - nb));
      end
    end
    bus.spics_n = 1'b1;
    repeat (8) @(negedge fclk);
  endtask

  initial begin
    bus.evt_stb  = 1'b0;
    bus.evt_data = 8'h00;
    bus.spics_n  = 1'b1;
    bus.spick    = 1'b0;
    bus.spido    = 1'b0;
    m_ovf        = 1'b0;
    chk_en       = 1'b0;
    rst          = 1'b1;
    repeat (4) @(negedge fclk);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge fclk);
    chk("reset spidi", {7'd0, bus.spidi}, 8'd1);
    chk("reset spiint_n", {7'd0, bus.spiint_n}, 8'd1);
    chk("reset evt_full", {7'd0, bus.evt_full}, 8'd0);
    chk("reset tx_active", {7'd0, bus.tx_active}, 8'd0);

    // Two bytes, three-byte frame.
    push(8'hA5);
    push(8'h3C);
    frame(3, 0, -1, 8'h00);
    chk("lit status 02", last_frame[0], 8'h02);
    chk("lit byte A5", last_frame[1], 8'hA5);
    chk("lit byte 3C", last_frame[2], 8'h3C);
    chk("lit spiint_n drained", {7'd0, bus.spiint_n}, 8'd1);

    // Empty FIFO read.
    frame(2, 0, -1, 8'h00);
    chk("lit empty status", last_frame[0], 8'h00);
    chk("lit empty filler", last_frame[1], 8'hFF);

    // Overflow by one.
    for (int i = 0; i < 17; i++) begin
      push(8'(i));
      if (i == 15) chk("lit full after 16", {7'd0, bus.evt_full}, 8'd1);
    end
    frame(17, 0, -1, 8'h00);
    chk("lit status 90", last_frame[0], 8'h90);
    chk("lit first data 00", last_frame[1], 8'h00);
    chk("lit last data 0F", last_frame[16], 8'h0F);
    frame(1, 0, -1, 8'h00);
    chk("lit ovf cleared", last_frame[0], 8'h00);

    // Abort mid data byte leaves the entry queued.
    push(8'h11);
    frame(1, 5, -1, 8'h00);
    frame(2, 0, -1, 8'h00);
    chk("lit abort status", last_frame[0], 8'h01);
    chk("lit abort data", last_frame[1], 8'h11);

    // Full FIFO, push coinciding with a data-byte commit.
    for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
    frame(2, 0, 1, 8'hC7);
    chk("lit still full", {7'd0, bus.evt_full}, 8'd1);
    frame(17, 0, -1, 8'h00);
    chk("lit status 10 no ovf", last_frame[0], 8'h10);
    chk("lit pushed tail C7", last_frame[16], 8'hC7);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      int np, nbytes, ab;
      np     = $urandom_range(0, 6);
      nbytes = $urandom_range(1, 5);
      ab     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < np; k++) push(8'($urandom_range(0, 255)));
      frame(nbytes, ab, -1, 8'h00);
    end

    // Reset in the middle of a frame.
    push(8'h21);
    push(8'h22);
    push(8'h23);
    bus.spics_n = 1'b0;
    repeat (6) @(negedge fclk);
    for (int i = 0; i < 11; i++) begin
      bus.spick = 1'b1;
      repeat (6) @(negedge fclk);
      bus.spick = 1'b0;
      repeat (6) @(negedge fclk);
    end
    rst         = 1'b1;
    bus.spics_n = 1'b1;
    m_q.delete();
    m_ovf = 1'b0;
    repeat (3) @(negedge fclk);
    rst = 1'b0;
    @(negedge fclk);
    chk("rst spidi", {7'd0, bus.spidi}, 8'd1);
    chk("rst spiint_n", {7'd0, bus.spiint_n}, 8'd1);
    chk("rst tx_active", {7'd0, bus.tx_active}, 8'd0);
    frame(1, 0, -1, 8'h00);
    chk("lit status after rst", last_frame[0], 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
